// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_t     responder FSM states
//   CNT_W       wait-state counter width (holds 0..15)
//   ALIGN_MASK  byte-offset bits that must be zero on a word access
//   ERR_*       values driven on Err at the access edge
//   range_mask  address bits lying above the word-index field
package dmem_pkg;

  localparam int CNT_W = 4;

  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_ADDR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Every address bit at or above the byte size of the array must be zero.
  function automatic logic [31:0] range_mask(input int depth_words);
    range_mask = ~((32'(depth_words) << 2) - 32'd1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32 storage with byte-enabled write and registered
// read. Both directions are gated by the single acc_en strobe; wr_en / rd_en
// qualify which side acts on that edge.
//   clk, rst_n      clock, async active-low reset (read register only)
//   acc_en          access strobe from the FSM
//   wr_en, rd_en    write commit / read select; when neither, rdata loads 0
//   idx             word index
//   wdata, byte_en  write data and per-byte enables
//   rdata           registered read data
module dmem_array #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           acc_en,
  input  logic                           wr_en,
  input  logic                           rd_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  input  logic [3:0]                     byte_en,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Storage is deliberately not reset so contents survive a Reset pulse.
  always_ff @(posedge clk) begin
    if (acc_en && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Writes and rejected accesses return zero, so the read register doubles
  // as the responder's RData output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rdata <= '0;
    else if (acc_en) rdata <= rd_en ? mem[idx] : '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-aligned load/store responder with programmable wait
// states and a Req/Ack handshake.
//   CLK, Reset            clock, async active-low reset
//   Req, WE, Addr,        request and its fields, captured in IDLE
//   WData, ByteEn
//   Ack                   one-cycle completion strobe
//   RData, Err            access result, valid while Ack=1
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for Req; captures the request fields
// ST_WAIT | counting wait states; access happens when counter hits 0
// ST_DONE | Ack high for one cycle with RData/Err from the access
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Req,
  input  logic        WE,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [3:0]  ByteEn,
  output logic        Ack,
  output logic [31:0] RData,
  output logic        Err
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RANGE_MASK = range_mask(DEPTH_WORDS);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic               capture;
  logic               access;
  logic               addr_err;
  logic [IDX_W-1:0]   idx;

  assign addr_err = (|(addr_q & ALIGN_MASK)) | (|(addr_q & RANGE_MASK));
  assign idx      = addr_q[IDX_W+1:2];

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          capture = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Fields are held from capture; a Req drop during WAIT does not matter.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (capture) begin
      cnt_q   <= CNT_W'(WAIT_CYCLES);
      we_q    <= WE;
      addr_q  <= Addr;
      wdata_q <= WData;
      be_q    <= ByteEn;
    end else if (state_q == ST_WAIT && cnt_q != '0) begin
      cnt_q   <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      Ack <= 1'b0;
      Err <= ERR_NONE;
    end else begin
      Ack <= (state_d == ST_DONE);
      if (access) Err <= addr_err ? ERR_ADDR : ERR_NONE;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (CLK),
    .rst_n   (Reset),
    .acc_en  (access),
    .wr_en   (we_q & ~addr_err),
    .rd_en   (~we_q & ~addr_err),
    .idx     (idx),
    .wdata   (wdata_q),
    .byte_en (be_q),
    .rdata   (RData)
  );

endmodule
